// File: rtl/jtopl_pkg.sv
// jtopl_pkg: OPL write-timing constants and write-buffer FSM encoding shared by
// the OPL variants.
package jtopl_pkg;
    localparam int OPL_ADDR_WAIT = 12;
    localparam int OPL_DATA_WAIT = 84;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } wr_state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m > 0 ? $clog2(m + 1) : 1;
    endfunction
endpackage

// File: rtl/jtopl_fifo.sv
// jtopl_fifo: fall-through FIFO with registered full/empty flags; accepts a push
// while full when a pop happens in the same cycle.
module jtopl_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic          do_push, do_pop;

    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign count_nx = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nx;
            full  <= count_nx == (AW+1)'(DEPTH);
            empty <= count_nx == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/jtopl_wrbuf.sv
// jtopl_wrbuf: buffers CPU writes and replays them to the OPL register map as
// single-clk strobes spaced by the chip's address/data write wait times.
module jtopl_wrbuf
    import jtopl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_WAIT = OPL_ADDR_WAIT,
    parameter int DATA_WAIT = OPL_DATA_WAIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_din,
    input  logic       ovf_clr,
    output logic       write,
    output logic       addr,
    output logic [7:0] din,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       ovf
);
    localparam int CW = cnt_width(ADDR_WAIT, DATA_WAIT);

    wr_state_t     state;
    logic [CW-1:0] cnt;
    logic [8:0]    head;
    logic          cpu_wr, cpu_wr_l, push_req, pop, drop, go;

    assign cpu_wr   = ~cs_n & ~wr_n;
    assign push_req = cpu_wr & ~cpu_wr_l;
    assign pop      = state == ISSUE;
    assign drop     = push_req & full & ~pop;
    // a queued entry is launched from IDLE or as soon as the running wait expires
    assign go       = ~empty & (state == IDLE || (state == WAIT && cnt == '0));
    assign busy     = state != IDLE || ~empty;

    jtopl_fifo #(.DEPTH(DEPTH), .W(9)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .din   ({cpu_addr, cpu_din}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            write    <= 1'b0;
            addr     <= 1'b0;
            din      <= 8'd0;
            cpu_wr_l <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            cpu_wr_l <= cpu_wr;
            ovf      <= drop | (ovf & ~ovf_clr);
            write    <= go;
            if (go) begin
                addr <= head[8];
                din  <= head[7:0];
            end
            case (state)
                IDLE:  if (go) state <= ISSUE;
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= addr ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
                end
                WAIT: begin
                    if (cnt != '0) begin
                        if (cen) cnt <= cnt - CW'(1);
                    end else begin
                        state <= go ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/jtopl_wrbuf.md
Name: jtopl_wrbuf

Overview:
- CPU-side write buffer directly upstream of the OPL register map.
- Captures CPU bus writes (address port and data port) into a small FIFO.
- Replays each captured write to the register map as a single-clk write strobe, spacing consecutive replays by the chip's address/data write wait times.
- Lets the host write at full speed without polling busy, while the register map sees chip-accurate write timing.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_WAIT, 12, cen ticks of wait after an address-port write is replayed.
- DATA_WAIT, 84, cen ticks of wait after a data-port write is replayed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen  in  1  chip clock enable; wait counters advance only on cen
- cs_n  in  1  CPU chip select, active low
- wr_n  in  1  CPU write strobe, active low
- cpu_addr  in  1  CPU port select: 0 = address port, 1 = data port
- cpu_din  in  8  CPU write data
- ovf_clr  in  1  clears the sticky overflow flag
- write  out  1  one-clk write strobe to the register map
- addr  out  1  port select accompanying write
- din  out  8  data accompanying write
- busy  out  1  FIFO non-empty or a replay wait in progress
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- ovf  out  1  sticky flag: a CPU write was dropped

Behaviour:
- Reset (asynchronous, rst_n=0):
  - write=0, addr=0, din=0, busy=0, full=0, empty=1, ovf=0.
  - FIFO pointers and count cleared; wait counter cleared; state IDLE.
  - Reset mid-operation discards all queued entries and any in-progress wait.
- Capture:
  - cpu_wr = ~cs_n & ~wr_n; register cpu_wr_l.
  - Push {cpu_addr, cpu_din} on the cycle where cpu_wr & ~cpu_wr_l.
  - A strobe held low for many cycles pushes exactly one entry.
- Push acceptance:
  - A push is accepted if count < DEPTH, or if a pop happens in the same cycle.
  - Otherwise the push is dropped and ovf is set to 1.
  - ovf_clr clears ovf. If ovf_clr and a drop occur in the same cycle, set wins.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: when FIFO is non-empty, go to ISSUE on the next clk.
  - ISSUE (exactly one clk):
    - write=1; addr/din driven from the FIFO head; pop.
    - Load the wait counter with ADDR_WAIT if the entry's addr=0, else DATA_WAIT.
    - Next state: WAIT.
  - WAIT:
    - Decrement the counter on each cen while counter != 0.
    - When counter == 0: go to ISSUE if the FIFO is non-empty, else IDLE.
- Outputs outside ISSUE:
  - write=0 in every state other than ISSUE.
  - addr/din hold their last issued values.
- Latency:
  - A push into an empty FIFO in IDLE produces the write pulse 2 clk after the push cycle.
  - With cen held high, consecutive pulses are wait+2 clk apart: 14 clk after an address write, 86 clk after a data write (defaults).
- Width rules:
  - Counter width is clog2(max(ADDR_WAIT, DATA_WAIT)+1).
  - A wait of 0 means WAIT lasts one clk.
- Flag timing:
  - full, empty and busy are registered and reflect the FIFO count after the current clk's push/pop.
  - busy = (state != IDLE) | ~empty.
- cen is ignored outside WAIT.

Decomposition:
- jtopl_pkg holds localparams OPL_ADDR_WAIT=12 and OPL_DATA_WAIT=84, and the FSM state encoding (IDLE=0, ISSUE=1, WAIT=2). These are shared with future OPL2/OPL3 variants.
- Sub-module jtopl_fifo:
  - Parameters: DEPTH, W=9.
  - Ports: clk, rst_n, push, pop, din, dout, full, empty.
  - Behaviour: accepts simultaneous push and pop when full; reads are fall-through (dout valid while non-empty).
- The FSM, edge detect and overflow logic remain in jtopl_wrbuf.

Test Plan:
1. cen=1; CPU writes cpu_addr=0, din=0x20 at cycle 10 → write=1 with addr=0, din=0x20 at cycle 12 only; busy=1 until FSM returns to IDLE at cycle 26.
2. Back-to-back writes (0, 0xA0), (1, 0x55), (0, 0xB0) with 2-clk gaps → pulses at T, T+14, T+100; values in order; empty=1 after the third pop.
3. Six writes in six consecutive strobes while the first wait is running, DEPTH=4 → four entries stored, the last write dropped, full=1, ovf=1. ovf_clr for 1 clk → ovf=0. Exactly five write pulses emitted in total.
4. cen asserted 1-in-4 clk; address write then data write → second pulse 12*4+2 clk (±3 for cen phase) after the first.
5. rst_n driven low during WAIT with 3 entries queued → write=0, empty=1, busy=0, ovf=0 immediately. No pulse after release until a new CPU write.
6. wr_n held low for 10 clk with cs_n=0 → exactly one entry pushed and one write pulse emitted; cs_n=1 with wr_n toggling → no push.
